// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter and its scoreboard.
package reg_wb_arbiter_pkg;

  localparam int XLEN    = 32;
  localparam int REG_NUM = 32;
  localparam int AW      = 5;
  localparam int CW      = 16;

  localparam logic [AW-1:0]   ZERO_REG     = 5'd0;
  localparam logic [XLEN-1:0] ZERO_WORD    = 32'd0;
  localparam logic            WRITE_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LD   = 2'd1,
    SRC_MD   = 2'd2,
    SRC_EX   = 2'd3
  } wb_src_e;

  // True when at least two of the three producers are requesting.
  function automatic logic multi_valid(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard for long-latency destinations, with operand busy lookup.
module reg_wb_arbiter_wb_scoreboard
  import reg_wb_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               set_valid_i,
  input  logic [AW-1:0]      set_rd_i,
  input  logic               clr_valid_i,
  input  logic [AW-1:0]      clr_rd_i,
  input  logic [AW-1:0]      chk_addr1_i,
  input  logic [AW-1:0]      chk_addr2_i,
  input  logic               fwd_we_i,
  input  logic [AW-1:0]      fwd_addr_i,
  output logic               busy1_o,
  output logic               busy2_o,
  output logic [REG_NUM-1:0] pending_o
);

  logic [REG_NUM-1:0] r_pending;
  logic [REG_NUM-1:0] w_pending_nxt;

  // The register file forwards the write in flight, so that cycle is not busy.
  function automatic logic busy_lookup(
    input logic [REG_NUM-1:0] pend,
    input logic [AW-1:0]      addr,
    input logic               fwd_we,
    input logic [AW-1:0]      fwd_addr
  );
    return pend[addr] && !(fwd_we && (fwd_addr == addr)) && (addr != ZERO_REG);
  endfunction

  // Set wins over clear; register 0 is never pending.
  always_comb begin
    w_pending_nxt = {REG_NUM{1'b0}};
    for (int i = 1; i < REG_NUM; i++) begin
      w_pending_nxt[i] = (set_valid_i && (set_rd_i == AW'(i))) ||
                         (r_pending[i] && !(clr_valid_i && (clr_rd_i == AW'(i))));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= {REG_NUM{1'b0}};
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign busy1_o   = busy_lookup(r_pending, chk_addr1_i, fwd_we_i, fwd_addr_i);
  assign busy2_o   = busy_lookup(r_pending, chk_addr2_i, fwd_we_i, fwd_addr_i);
  assign pending_o = r_pending;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: merges ld/md/ex results onto the single register file write
// port through one registered stage, and tracks pending long-latency writes.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid_i,
  input  logic [AW-1:0]      issue_rd_i,
  input  logic               ex_valid_i,
  input  logic [AW-1:0]      ex_rd_i,
  input  logic [XLEN-1:0]    ex_data_i,
  output logic               ex_ready_o,
  input  logic               ld_valid_i,
  input  logic [AW-1:0]      ld_rd_i,
  input  logic [XLEN-1:0]    ld_data_i,
  output logic               ld_ready_o,
  input  logic               md_valid_i,
  input  logic [AW-1:0]      md_rd_i,
  input  logic [XLEN-1:0]    md_data_i,
  output logic               md_ready_o,
  input  logic [AW-1:0]      chk_addr1_i,
  input  logic [AW-1:0]      chk_addr2_i,
  output logic               busy1_o,
  output logic               busy2_o,
  output logic               we_o,
  output logic [AW-1:0]      waddr_o,
  output logic [XLEN-1:0]    wdata_o,
  output logic [REG_NUM-1:0] pending_o,
  output logic [CW-1:0]      conflict_cnt_o
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  wb_src_e         w_sel;
  logic [AW-1:0]   w_acc_rd;
  logic [XLEN-1:0] w_acc_data;
  logic            w_accept;
  logic            w_clr_valid;
  logic            w_multi;

  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic [CW-1:0]   r_conflict_cnt;

  // Fixed priority ld > md > ex; nothing is granted while in reset.
  always_comb begin
    w_sel = SRC_NONE;
    if (rst) begin
      w_sel = SRC_NONE;
    end else if (ld_valid_i) begin
      w_sel = SRC_LD;
    end else if (md_valid_i) begin
      w_sel = SRC_MD;
    end else if (ex_valid_i) begin
      w_sel = SRC_EX;
    end else begin
      w_sel = SRC_NONE;
    end
  end

  always_comb begin
    w_acc_rd   = ZERO_REG;
    w_acc_data = ZERO_WORD;
    case (w_sel)
      SRC_LD: begin
        w_acc_rd   = ld_rd_i;
        w_acc_data = ld_data_i;
      end
      SRC_MD: begin
        w_acc_rd   = md_rd_i;
        w_acc_data = md_data_i;
      end
      SRC_EX: begin
        w_acc_rd   = ex_rd_i;
        w_acc_data = ex_data_i;
      end
      default: begin
        w_acc_rd   = ZERO_REG;
        w_acc_data = ZERO_WORD;
      end
    endcase
  end

  assign ld_ready_o  = (w_sel == SRC_LD);
  assign md_ready_o  = (w_sel == SRC_MD);
  assign ex_ready_o  = (w_sel == SRC_EX);
  assign w_accept    = (w_sel != SRC_NONE);
  assign w_clr_valid = (w_sel == SRC_LD) || (w_sel == SRC_MD);
  assign w_multi     = multi_valid(ld_valid_i, md_valid_i, ex_valid_i);

  // rd=0 results are consumed but leave address/data untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= ZERO_REG;
      r_wdata <= ZERO_WORD;
    end else if (w_accept && (w_acc_rd != ZERO_REG)) begin
      r_we    <= WRITE_ENABLE;
      r_waddr <= w_acc_rd;
      r_wdata <= w_acc_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= {CW{1'b0}};
    end else if (w_multi && (r_conflict_cnt != CNT_MAX)) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_ONE;
    end else begin
      r_conflict_cnt <= r_conflict_cnt;
    end
  end

  reg_wb_arbiter_wb_scoreboard u_wb_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_valid_i (issue_valid_i),
    .set_rd_i    (issue_rd_i),
    .clr_valid_i (w_clr_valid),
    .clr_rd_i    (w_acc_rd),
    .chk_addr1_i (chk_addr1_i),
    .chk_addr2_i (chk_addr2_i),
    .fwd_we_i    (r_we),
    .fwd_addr_i  (r_waddr),
    .busy1_o     (busy1_o),
    .busy2_o     (busy2_o),
    .pending_o   (pending_o)
  );

  assign we_o           = r_we;
  assign waddr_o        = r_waddr;
  assign wdata_o        = r_wdata;
  assign conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed table-driven bench for reg_wb_arbiter plus reset corner sequences.
module tb_reg_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        ex_valid_i, ld_valid_i, md_valid_i;
  logic [4:0]  ex_rd_i, ld_rd_i, md_rd_i;
  logic [31:0] ex_data_i, ld_data_i, md_data_i;
  logic        ex_ready_o, ld_ready_o, md_ready_o;
  logic [4:0]  chk_addr1_i, chk_addr2_i;
  logic        busy1_o, busy2_o;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic [31:0] pending_o;
  logic [15:0] conflict_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_row = -1;

  reg_wb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid_i  (issue_valid_i),
    .issue_rd_i     (issue_rd_i),
    .ex_valid_i     (ex_valid_i),
    .ex_rd_i        (ex_rd_i),
    .ex_data_i      (ex_data_i),
    .ex_ready_o     (ex_ready_o),
    .ld_valid_i     (ld_valid_i),
    .ld_rd_i        (ld_rd_i),
    .ld_data_i      (ld_data_i),
    .ld_ready_o     (ld_ready_o),
    .md_valid_i     (md_valid_i),
    .md_rd_i        (md_rd_i),
    .md_data_i      (md_data_i),
    .md_ready_o     (md_ready_o),
    .chk_addr1_i    (chk_addr1_i),
    .chk_addr2_i    (chk_addr2_i),
    .busy1_o        (busy1_o),
    .busy2_o        (busy2_o),
    .we_o           (we_o),
    .waddr_o        (waddr_o),
    .wdata_o        (wdata_o),
    .pending_o      (pending_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ldv; logic [4:0] ldrd; logic [31:0] ldd;
    logic        mdv; logic [4:0] mdrd; logic [31:0] mdd;
    logic        exv; logic [4:0] exrd; logic [31:0] exd;
    logic        isv; logic [4:0] isrd;
    logic [4:0]  c1;  logic [4:0] c2;
    logic [2:0]  rdy; logic we; logic [4:0] wa; logic [31:0] wd;
    logic [31:0] pend; logic b1; logic b2; logic [15:0] cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, cur_row, act, exp);
    end
  endtask

  task automatic drive_idle();
    issue_valid_i = 1'b0; issue_rd_i = 5'd0;
    ld_valid_i = 1'b0; ld_rd_i = 5'd0; ld_data_i = 32'd0;
    md_valid_i = 1'b0; md_rd_i = 5'd0; md_data_i = 32'd0;
    ex_valid_i = 1'b0; ex_rd_i = 5'd0; ex_data_i = 32'd0;
    chk_addr1_i = 5'd0; chk_addr2_i = 5'd0;
  endtask

  task automatic check_regs(input logic exp_we, input logic [4:0] exp_wa, input logic [31:0] exp_wd,
                            input logic [31:0] exp_pend, input logic [15:0] exp_cnt);
    chk("we", {31'd0, we_o}, {31'd0, exp_we});
    chk("waddr", {27'd0, waddr_o}, {27'd0, exp_wa});
    chk("wdata", wdata_o, exp_wd);
    chk("pending", pending_o, exp_pend);
    chk("conflict_cnt", {16'd0, conflict_cnt_o}, {16'd0, exp_cnt});
  endtask

  initial begin
    // ldv rd data | mdv rd data | exv rd data | isv rd | c1 c2 || rdy we wa wd pend b1 b2 cnt
    vecs[0]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd5,32'h1234, 1'b0,5'd0, 5'd0,5'd0, 3'b001,1'b0,5'd0,32'h0, 32'h0,1'b0,1'b0,16'd0};
    vecs[1]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd0,5'd0, 3'b000,1'b1,5'd5,32'h1234, 32'h0,1'b0,1'b0,16'd0};
    vecs[2]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd0,5'd0, 3'b000,1'b0,5'd5,32'h1234, 32'h0,1'b0,1'b0,16'd0};
    vecs[3]  = '{1'b1,5'd1,32'h11, 1'b1,5'd2,32'h22, 1'b1,5'd3,32'h33, 1'b0,5'd0, 5'd0,5'd0, 3'b100,1'b0,5'd5,32'h1234, 32'h0,1'b0,1'b0,16'd0};
    vecs[4]  = '{1'b0,5'd0,32'h0, 1'b1,5'd2,32'h22, 1'b1,5'd3,32'h33, 1'b0,5'd0, 5'd0,5'd0, 3'b010,1'b1,5'd1,32'h11, 32'h0,1'b0,1'b0,16'd1};
    vecs[5]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd3,32'h33, 1'b0,5'd0, 5'd0,5'd0, 3'b001,1'b1,5'd2,32'h22, 32'h0,1'b0,1'b0,16'd2};
    vecs[6]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd0,5'd0, 3'b000,1'b1,5'd3,32'h33, 32'h0,1'b0,1'b0,16'd2};
    vecs[7]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd7, 5'd7,5'd0, 3'b000,1'b0,5'd3,32'h33, 32'h0,1'b0,1'b0,16'd2};
    vecs[8]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7,5'd0, 3'b000,1'b0,5'd3,32'h33, 32'h80,1'b1,1'b0,16'd2};
    vecs[9]  = '{1'b1,5'd7,32'h77, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7,5'd7, 3'b100,1'b0,5'd3,32'h33, 32'h80,1'b1,1'b1,16'd2};
    vecs[10] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7,5'd0, 3'b000,1'b1,5'd7,32'h77, 32'h0,1'b0,1'b0,16'd2};
    vecs[11] = '{1'b0,5'd0,32'h0, 1'b1,5'd9,32'h99, 1'b0,5'd0,32'h0, 1'b1,5'd9, 5'd9,5'd0, 3'b010,1'b0,5'd7,32'h77, 32'h0,1'b0,1'b0,16'd2};
    vecs[12] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd9,5'd0, 3'b000,1'b1,5'd9,32'h99, 32'h200,1'b0,1'b0,16'd2};
    vecs[13] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd9,5'd0, 3'b000,1'b0,5'd9,32'h99, 32'h200,1'b1,1'b0,16'd2};
    vecs[14] = '{1'b0,5'd0,32'h0, 1'b1,5'd9,32'h5, 1'b0,5'd0,32'h0, 1'b1,5'd0, 5'd0,5'd0, 3'b010,1'b0,5'd9,32'h99, 32'h200,1'b0,1'b0,16'd2};
    vecs[15] = '{1'b1,5'd0,32'hdead, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd0,5'd0, 3'b100,1'b1,5'd9,32'h5, 32'h0,1'b0,1'b0,16'd2};
    vecs[16] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd10, 5'd0,5'd0, 3'b000,1'b0,5'd9,32'h5, 32'h0,1'b0,1'b0,16'd2};
    vecs[17] = '{1'b0,5'd0,32'h0, 1'b1,5'd6,32'h66, 1'b1,5'd4,32'h44, 1'b0,5'd0, 5'd0,5'd0, 3'b010,1'b0,5'd9,32'h5, 32'h400,1'b0,1'b0,16'd2};
    vecs[18] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd4,32'h44, 1'b0,5'd0, 5'd0,5'd0, 3'b001,1'b1,5'd6,32'h66, 32'h400,1'b0,1'b0,16'd3};
    vecs[19] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd10,32'ha, 1'b0,5'd0, 5'd10,5'd0, 3'b001,1'b1,5'd4,32'h44, 32'h400,1'b1,1'b0,16'd3};
    vecs[20] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd10,5'd0, 3'b000,1'b1,5'd10,32'ha, 32'h400,1'b0,1'b0,16'd3};
    vecs[21] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd10,5'd0, 3'b000,1'b0,5'd10,32'ha, 32'h400,1'b1,1'b0,16'd3};

    // Reset with a pending request: nothing granted, all state cleared.
    drive_idle();
    rst = 1'b1;
    ex_valid_i = 1'b1; ex_rd_i = 5'd3; ex_data_i = 32'h5a5a;
    repeat (2) @(negedge clk);
    #2;
    chk("ready_in_reset", {29'd0, ld_ready_o, md_ready_o, ex_ready_o}, 32'd0);
    check_regs(1'b0, 5'd0, 32'd0, 32'd0, 16'd0);
    drive_idle();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      cur_row = i;
      ld_valid_i = vecs[i].ldv; ld_rd_i = vecs[i].ldrd; ld_data_i = vecs[i].ldd;
      md_valid_i = vecs[i].mdv; md_rd_i = vecs[i].mdrd; md_data_i = vecs[i].mdd;
      ex_valid_i = vecs[i].exv; ex_rd_i = vecs[i].exrd; ex_data_i = vecs[i].exd;
      issue_valid_i = vecs[i].isv; issue_rd_i = vecs[i].isrd;
      chk_addr1_i = vecs[i].c1; chk_addr2_i = vecs[i].c2;
      #2;
      chk("ready", {29'd0, ld_ready_o, md_ready_o, ex_ready_o}, {29'd0, vecs[i].rdy});
      check_regs(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].pend, vecs[i].cnt);
      chk("busy1", {31'd0, busy1_o}, {31'd0, vecs[i].b1});
      chk("busy2", {31'd0, busy2_o}, {31'd0, vecs[i].b2});
    end

    // Load accepted, then reset asserted before it retires.
    cur_row = 100;
    @(negedge clk);
    drive_idle();
    ld_valid_i = 1'b1; ld_rd_i = 5'd3; ld_data_i = 32'hbeef;
    #2;
    chk("ld_ready_pre_reset", {31'd0, ld_ready_o}, 32'd1);
    @(negedge clk);
    cur_row = 101;
    rst = 1'b1;
    md_valid_i = 1'b1; md_rd_i = 5'd12; md_data_i = 32'h12;
    issue_valid_i = 1'b1; issue_rd_i = 5'd12;
    #2;
    chk("ready_during_reset", {29'd0, ld_ready_o, md_ready_o, ex_ready_o}, 32'd0);
    @(negedge clk);
    cur_row = 102;
    #2;
    chk("ready_held_reset", {29'd0, ld_ready_o, md_ready_o, ex_ready_o}, 32'd0);
    check_regs(1'b0, 5'd0, 32'd0, 32'd0, 16'd0);
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    cur_row = 103;
    #2;
    check_regs(1'b0, 5'd0, 32'd0, 32'd0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
